burst_sched_arbiter: RTL and testbench

//  Shares one one-shot burst sequencer (start/step_wdth in, busy out) among N_REQ requesters.

---
 rtl/burst_sched_pkg.sv | 19 +
 rtl/rr_pick.sv | 33 +++
 rtl/burst_sched_arbiter.sv | 154 +++++++++++++++
 tb/tb_burst_sched_arbiter.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/burst_sched_pkg.sv
// Shared types and helpers for the burst scheduler and its round-robin picker.
package burst_sched_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        WAIT_BSY,
        RUN,
        GAP,
        ABORT
    } state_t;

    localparam int WDTH_W = 32;

    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set req bit at or above ptr, with wrap.
module rr_pick #(
    parameter int N    = 4,
    parameter int ID_W = 2
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] ptr,
    output logic            valid,
    output logic [ID_W-1:0] id,
    output logic [N-1:0]    onehot
);

    logic [ID_W:0] idx;

    always_comb begin
        valid  = 1'b0;
        id     = '0;
        onehot = '0;
        idx    = '0;
        for (int k = 0; k < N; k++) begin
            idx = {1'b0, ptr} + (ID_W+1)'(k);
            if (idx >= (ID_W+1)'(N))
                idx = idx - (ID_W+1)'(N);
            if (!valid && req[idx[ID_W-1:0]]) begin
                valid = 1'b1;
                id    = idx[ID_W-1:0];
            end
        end
        if (valid)
            onehot[id] = 1'b1;
    end

endmodule

// File: rtl/burst_sched_arbiter.sv
// Round-robin owner of a shared one-shot burst sequencer with enforced idle gap.
// Optional burst watchdog with sequencer abort: define BURST_SCHED_WDOG_EN.
module burst_sched_arbiter
    import burst_sched_pkg::*;
#(
    parameter int  N_REQ          = 4,
    parameter int  GAP_CYCLES     = 2,
    parameter int  TIMEOUT_CYCLES = 65536,
    localparam int ID_W           = clog2_min1(N_REQ)
) (
    input  logic                      clk,
    input  logic                      nrst,
    input  logic [N_REQ-1:0]          req,
    input  logic [WDTH_W*N_REQ-1:0]   req_wdth,
    output logic [N_REQ-1:0]          gnt,
    output logic [N_REQ-1:0]          done,
    output logic                      seq_start,
    output logic [WDTH_W-1:0]         seq_step_wdth,
    output logic                      seq_nrst,
    input  logic                      seq_busy,
    output logic [ID_W-1:0]           active_id,
    output logic                      sched_busy,
    output logic                      aborted
);

    if (N_REQ < 2 || N_REQ > 16 || GAP_CYCLES < 0 || GAP_CYCLES > 255 ||
        TIMEOUT_CYCLES < 1) begin : g_bad_param
        $error("burst_sched_arbiter: parameter out of range");
    end

    state_t          state;
    logic [ID_W-1:0] rr_ptr;
    logic [7:0]      gap_cnt;
    logic            pick_valid;
    logic [ID_W-1:0] pick_id;
    logic [N_REQ-1:0] pick_onehot;

    rr_pick #(
        .N    (N_REQ),
        .ID_W (ID_W)
    ) u_pick (
        .req    (req),
        .ptr    (rr_ptr),
        .valid  (pick_valid),
        .id     (pick_id),
        .onehot (pick_onehot)
    );

    assign sched_busy = (state != IDLE);

`ifdef BURST_SCHED_WDOG_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WD_W-1:0] wdog_cnt;
    logic            wdog_hit;

    assign wdog_hit = (wdog_cnt >= WD_W'(TIMEOUT_CYCLES - 1));
`else
    assign seq_nrst = 1'b1;
    assign aborted  = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state         <= IDLE;
            rr_ptr        <= '0;
            gap_cnt       <= '0;
            gnt           <= '0;
            done          <= '0;
            seq_start     <= 1'b0;
            seq_step_wdth <= '0;
            active_id     <= '0;
`ifdef BURST_SCHED_WDOG_EN
            wdog_cnt      <= '0;
            seq_nrst      <= 1'b1;
            aborted       <= 1'b0;
`endif
        end else begin
            gnt       <= '0;
            done      <= '0;
            seq_start <= 1'b0;
`ifdef BURST_SCHED_WDOG_EN
            seq_nrst  <= 1'b1;
            aborted   <= 1'b0;
`endif
            unique case (state)
                IDLE: begin
                    // a stale busy from the sequencer blocks any new grant
                    if (pick_valid && !seq_busy) begin
                        gnt           <= pick_onehot;
                        active_id     <= pick_id;
                        seq_step_wdth <= req_wdth[WDTH_W*pick_id +: WDTH_W];
                        rr_ptr        <= (pick_id == ID_W'(N_REQ - 1)) ?
                                         '0 : pick_id + 1'b1;
                        state         <= START;
                    end
                end
                START: begin
                    seq_start <= 1'b1;
`ifdef BURST_SCHED_WDOG_EN
                    wdog_cnt  <= '0;
`endif
                    state     <= WAIT_BSY;
                end
                WAIT_BSY: begin
`ifdef BURST_SCHED_WDOG_EN
                    wdog_cnt <= wdog_cnt + 1'b1;
`endif
                    if (seq_busy) begin
                        state <= RUN;
`ifdef BURST_SCHED_WDOG_EN
                    end else if (wdog_hit) begin
                        seq_nrst        <= 1'b0;
                        aborted         <= 1'b1;
                        done[active_id] <= 1'b1;
                        state           <= ABORT;
`endif
                    end
                end
                RUN: begin
`ifdef BURST_SCHED_WDOG_EN
                    wdog_cnt <= wdog_cnt + 1'b1;
`endif
                    if (!seq_busy) begin
                        done[active_id] <= 1'b1;
                        gap_cnt         <= '0;
                        state           <= (GAP_CYCLES == 0) ? IDLE : GAP;
`ifdef BURST_SCHED_WDOG_EN
                    end else if (wdog_hit) begin
                        seq_nrst        <= 1'b0;
                        aborted         <= 1'b1;
                        done[active_id] <= 1'b1;
                        state           <= ABORT;
`endif
                    end
                end
                GAP: begin
                    if (gap_cnt == 8'(GAP_CYCLES - 1))
                        state <= IDLE;
                    else
                        gap_cnt <= gap_cnt + 1'b1;
                end
`ifdef BURST_SCHED_WDOG_EN
                ABORT: begin
                    gap_cnt <= '0;
                    state   <= (GAP_CYCLES == 0) ? IDLE : GAP;
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_burst_sched_arbiter.sv
// Randomized bench for burst_sched_arbiter against a timestamp-based reference model.
module tb_burst_sched_arbiter;

    localparam int N   = 4;
    localparam int GAP = 2;
    localparam int TMO = 100;
    localparam int W   = 32;

    logic             clk = 1'b0;
    logic             nrst;
    logic [N-1:0]     req;
    logic [W*N-1:0]   req_wdth;
    logic [N-1:0]     gnt;
    logic [N-1:0]     done;
    logic             seq_start;
    logic [W-1:0]     seq_step_wdth;
    logic             seq_nrst;
    logic             seq_busy;
    logic [1:0]       active_id;
    logic             sched_busy;
    logic             aborted;

    always #5 clk = ~clk;

    burst_sched_arbiter #(
        .N_REQ          (N),
        .GAP_CYCLES     (GAP),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk           (clk),
        .nrst          (nrst),
        .req           (req),
        .req_wdth      (req_wdth),
        .gnt           (gnt),
        .done          (done),
        .seq_start     (seq_start),
        .seq_step_wdth (seq_step_wdth),
        .seq_nrst      (seq_nrst),
        .seq_busy      (seq_busy),
        .active_id     (active_id),
        .sched_busy    (sched_busy),
        .aborted       (aborted)
    );

    int checks  = 0;
    int errors  = 0;
    int cyc     = 0;
    int n_gnt   = 0;
    int n_abort = 0;
    int mode    = 0;

    // model: burst in flight, when scheduler may next grant, when start appears
    bit         m_fly   = 1'b0;
    bit         m_seen  = 1'b0;
    int         m_free  = 0;
    int         m_start = -1;
    int         m_owner = 0;
    int         m_ptr   = 0;
    logic [W-1:0] m_wdth = '0;

    bit sq_act = 1'b0;
    bit stuck  = 1'b0;
    int sq_lat = 0;
    int sq_len = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic step();
        logic [N-1:0] e_gnt;
        logic [N-1:0] e_done;
        bit           e_abort;
        int           w;
        int           j;
        @(negedge clk);
        cyc++;
        e_gnt   = '0;
        e_done  = '0;
        e_abort = 1'b0;
        w       = -1;
        // inputs still hold last cycle's values here
        if (!nrst) begin
            m_fly   = 1'b0;
            m_seen  = 1'b0;
            m_ptr   = 0;
            m_owner = 0;
            m_wdth  = '0;
            m_free  = cyc;
            m_start = -1;
        end else if (m_fly) begin
            if (cyc - 1 >= m_start) begin
                if (m_seen && !seq_busy) begin
                    e_done[m_owner] = 1'b1;
                    m_fly  = 1'b0;
                    m_free = cyc + GAP;
                end else if (!m_seen && seq_busy) begin
                    m_seen = 1'b1;
`ifdef BURST_SCHED_WDOG_EN
                end else if (cyc - 1 - m_start >= TMO - 1) begin
                    e_abort         = 1'b1;
                    e_done[m_owner] = 1'b1;
                    m_fly  = 1'b0;
                    m_free = cyc + 1 + GAP;
                    n_abort++;
`endif
                end
            end
        end else if (cyc - 1 >= m_free && req != '0 && !seq_busy) begin
            for (int k = 0; k < N; k++) begin
                j = (m_ptr + k) % N;
                if (w < 0 && req[j])
                    w = j;
            end
            e_gnt[w] = 1'b1;
            m_owner  = w;
            m_wdth   = req_wdth[W*w +: W];
            m_ptr    = (w + 1) % N;
            m_fly    = 1'b1;
            m_seen   = 1'b0;
            m_start  = cyc + 1;
            n_gnt++;
        end

        check("gnt", 32'(gnt), 32'(e_gnt));
        check("done", 32'(done), 32'(e_done));
        check("seq_start", 32'(seq_start), 32'(cyc == m_start));
        check("step_wdth", seq_step_wdth, m_wdth);
        check("active_id", 32'(active_id), 32'(m_owner));
        check("sched_busy", 32'(sched_busy), 32'(m_fly || cyc < m_free));
        check("aborted", 32'(aborted), 32'(e_abort));
        check("seq_nrst", 32'(seq_nrst), 32'(!e_abort));

        // sequencer stand-in
        if (seq_start) begin
            sq_act = 1'b1;
            sq_lat = $urandom_range(0, 2);
            sq_len = $urandom_range(1, 6);
        end
        if (!nrst || !seq_nrst)
            sq_act = 1'b0;
        if (sq_act) begin
            if (sq_lat > 0) begin
                seq_busy = 1'b0;
                sq_lat--;
            end else if (stuck) begin
                seq_busy = 1'b1;
            end else if (sq_len > 0) begin
                seq_busy = 1'b1;
                sq_len--;
            end else begin
                seq_busy = 1'b0;
                sq_act   = 1'b0;
            end
        end else begin
            seq_busy = (mode == 0) && ($urandom_range(0, 15) == 0);
        end

        // requesters
        case (mode)
            0: begin
                for (int i = 0; i < N; i++) begin
                    if (gnt[i] && $urandom_range(0, 1) == 1)
                        req[i] = 1'b0;
                    else if (!req[i] && $urandom_range(0, 3) == 0)
                        req[i] = 1'b1;
                    else if (req[i] && !gnt[i] && $urandom_range(0, 39) == 0)
                        req[i] = 1'b0;
                    if ($urandom_range(0, 7) == 0)
                        req_wdth[W*i +: W] = $urandom;
                end
                nrst = ($urandom_range(0, 299) != 0);
            end
            1: begin
                req = '1;
                for (int i = 0; i < N; i++)
                    if ($urandom_range(0, 7) == 0)
                        req_wdth[W*i +: W] = $urandom;
                nrst = 1'b1;
            end
            2: begin
                req   = 4'b0001;
                stuck = 1'b1;
                nrst  = 1'b1;
            end
            3: nrst = 1'b0;
            default: begin
                if (gnt[0])
                    req = '0;
                nrst = 1'b1;
            end
        endcase
    endtask

    initial begin
        nrst     = 1'b0;
        req      = '0;
        req_wdth = '0;
        seq_busy = 1'b0;

        mode = 3;
        repeat (3) step();

        mode = 4;
        req  = 4'b0001;
        req_wdth[31:0] = 32'd5;
        repeat (20) step();

        mode = 0;
        repeat (2000) step();

        mode = 1;
        repeat (300) step();

`ifdef BURST_SCHED_WDOG_EN
        mode = 2;
        repeat (400) step();
        stuck = 1'b0;
        check("abort_count", 32'(n_abort >= 2), 32'd1);
`endif

        check("grant_count", 32'(n_gnt >= 20), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
